// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Types and constants shared by the hazard controller and its pieces.
//
// Contents:
//   hz_state_t       FSM state: RUN (normal flow) or MISS (waiting for the
//                    data cache to return the missed access)
//   FWD_RF/W/M       ALU operand forward selects
//   RESULT_SRC_LOAD  ResultSrcE encoding that marks a load in E
//   reg_hit()        nonzero register-address match helper
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } hz_state_t;

  // ALU operand forward select encodings
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // result from writeback stage
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU result from memory stage

  // ResultSrcE value identifying a load instruction in E
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // True when a producer address matches a consumer address and is not x0.
  // x0 is hardwired to zero, so it never creates a real dependency.
  // The address width is fixed to 5 bits here (RV32I register file).
  function automatic logic reg_hit(input logic [4:0] producer,
                                   input logic [4:0] consumer);
    return (producer != 5'd0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_if
//
// Bundle of pipeline status inputs and hazard control outputs exchanged
// between the core pipeline and the hazard controller.
//
// Modports:
//   master  pipeline side: drives register addresses, load/branch/cache
//           status; receives stall, flush, forward and counter values
//   slave   hazard controller side (mirror of master)
//
// Signals (pipeline -> controller):
//   Rs1D, Rs2D          decode-stage source registers
//   Rs1E, Rs2E, RdE     execute-stage sources and destination
//   ResultSrcE          2'b01 marks a load in E
//   PCSrcE              taken branch or jump resolved in E
//   RegWriteM, RdM      memory-stage write-back info
//   RegWriteW, RdW      writeback-stage write-back info
//   CacheMissM          data-cache miss for the access in M
//   CacheReadyM         miss data valid this cycle
// Signals (controller -> pipeline):
//   StallF/D/E/M        hold the respective pipeline register
//   FlushD/E/W          clear the respective pipeline register
//   ForwardAE/BE        ALU operand forward selects
//   StallCycles         saturating count of cycles with any stall
//   FlushCycles         saturating count of cycles with FlushD
// -----------------------------------------------------------------------------
interface hazard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] Rs1D;
  logic [ADDR_WIDTH-1:0] Rs2D;
  logic [ADDR_WIDTH-1:0] Rs1E;
  logic [ADDR_WIDTH-1:0] Rs2E;
  logic [ADDR_WIDTH-1:0] RdE;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE;
  logic                  RegWriteM;
  logic [ADDR_WIDTH-1:0] RdM;
  logic                  RegWriteW;
  logic [ADDR_WIDTH-1:0] RdW;
  logic                  CacheMissM;
  logic                  CacheReadyM;

  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [DATA_WIDTH-1:0] StallCycles;
  logic [DATA_WIDTH-1:0] FlushCycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RegWriteM, RdM, RegWriteW, RdW, CacheMissM, CacheReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCycles, FlushCycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RegWriteM, RdM, RegWriteW, RdW, CacheMissM, CacheReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCycles, FlushCycles
  );

endinterface

// File: rtl/hazard_controller_forward_sel.sv
// -----------------------------------------------------------------------------
// forward_sel
//
// Combinational forwarding selector for one ALU operand in E. The memory
// stage holds the younger result, so it takes priority over writeback.
//
// Ports:
//   rs_e         execute-stage source register for this operand
//   reg_write_m  memory-stage instruction writes a register
//   rd_m         memory-stage destination register
//   reg_write_w  writeback-stage instruction writes a register
//   rd_w         writeback-stage destination register
//   sel          FWD_M, FWD_W or FWD_RF
// -----------------------------------------------------------------------------
module forward_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs_e,
  input  logic                  reg_write_m,
  input  logic [ADDR_WIDTH-1:0] rd_m,
  input  logic                  reg_write_w,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  output logic [1:0]            sel
);

  logic hit_m;
  logic hit_w;

  // x0 never produces a forwardable value.
  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  always_comb begin
    // NOTE: assigning a default before any branch guarantees every path
    // drives sel, so no latch is inferred.
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard and stall/flush sequencer for the 5-stage RV32I core.
// Drives the stall/clear controls of the F, D, E, M and W pipeline
// registers, selects ALU operand forwarding, and counts stall/flush cycles.
//
// Ports:
//   clk   core clock
//   rst   synchronous active-high reset
//   hz    hazard_if.slave bundle (see hazard_controller_if.sv)
//
// Priority of the control decisions, highest first:
//   rst > data-cache miss stall > taken branch/jump flush > load-use stall
//
// A miss freezes F..M and bubbles W; a branch resolved in E during a miss
// is simply left on PCSrcE (E is held) and acted on in the release cycle.
// -----------------------------------------------------------------------------
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);

  hz_state_t state;
  hz_state_t state_next;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  logic miss_stall;
  logic load_use;

  logic stall_f;
  logic stall_d;
  logic stall_e;
  logic stall_m;
  logic flush_d;
  logic flush_e;
  logic flush_w;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic any_stall;

  logic [DATA_WIDTH-1:0] stall_cnt;
  logic [DATA_WIDTH-1:0] flush_cnt;

  // ---------------------------------------------------------------------------
  // Operand forwarding (computed in every FSM state)
  // ---------------------------------------------------------------------------
  forward_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs_e        (hz.Rs1E),
    .reg_write_m (hz.RegWriteM),
    .rd_m        (hz.RdM),
    .reg_write_w (hz.RegWriteW),
    .rd_w        (hz.RdW),
    .sel         (fwd_a)
  );

  forward_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs_e        (hz.Rs2E),
    .reg_write_m (hz.RegWriteM),
    .rd_m        (hz.RdM),
    .reg_write_w (hz.RegWriteW),
    .rd_w        (hz.RdW),
    .sel         (fwd_b)
  );

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A load in E whose destination is read by the instruction in D cannot
  // forward in time; one bubble lets the value arrive via W instead.
  assign load_use = (hz.ResultSrcE == RESULT_SRC_LOAD) &&
                    (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Miss and ready together in RUN is a hit; in MISS, ready is the release.
  assign miss_stall = ((state == RUN)  && hz.CacheMissM && !hz.CacheReadyM) ||
                      ((state == MISS) && !hz.CacheReadyM);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (hz.CacheMissM && !hz.CacheReadyM) state_next = MISS;
      MISS:    if (hz.CacheReadyM)                   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall / flush / forward outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    forward_a = fwd_a;
    forward_b = fwd_b;

    if (rst) begin
      // Clear every downstream register while reset is held.
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_w   = 1'b1;
      forward_a = FWD_RF;
      forward_b = FWD_RF;
    end else if (miss_stall) begin
      // Freeze F..M; W gets a bubble so the stalled M result is not
      // written back twice. D/E are held, not cleared, so a pending
      // branch in E survives until release.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      // Wrong-path instructions in D and E are discarded; any load-use
      // stall for them is pointless, so it is dropped.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign any_stall = stall_f | stall_d | stall_e | stall_m;

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.ForwardAE   = forward_a;
  assign hz.ForwardBE   = forward_b;
  assign hz.StallCycles = stall_cnt;
  assign hz.FlushCycles = flush_cnt;

  // ---------------------------------------------------------------------------
  // State register and saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (any_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + DATA_WIDTH'(1);
      end
      if (flush_d && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed self-checking bench for hazard_controller. Counters are built
// 8 bits wide so saturation is reachable in a few hundred cycles.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 time unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int TB_DW = 8;
  localparam int TB_AW = 5;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  logic [TB_DW-1:0] exp_stall;
  logic [TB_DW-1:0] exp_flush;
  logic [TB_DW-1:0] all_ones;

  hazard_if #(.DATA_WIDTH(TB_DW), .ADDR_WIDTH(TB_AW)) hz ();

  hazard_controller #(.DATA_WIDTH(TB_DW), .ADDR_WIDTH(TB_AW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.Rs1D        = '0;
    hz.Rs2D        = '0;
    hz.Rs1E        = '0;
    hz.Rs2E        = '0;
    hz.RdE         = '0;
    hz.ResultSrcE  = 2'b00;
    hz.PCSrcE      = 1'b0;
    hz.RegWriteM   = 1'b0;
    hz.RdM         = '0;
    hz.RegWriteW   = 1'b0;
    hz.RdW         = '0;
    hz.CacheMissM  = 1'b0;
    hz.CacheReadyM = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_stalls: got %b expected 0000",
               {hz.StallF, hz.StallD, hz.StallE, hz.StallM});
    end
    n_cmp++;
    if ({hz.FlushD, hz.FlushE, hz.FlushW} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_flushes: got %b expected 111",
               {hz.FlushD, hz.FlushE, hz.FlushW});
    end
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {TB_DW{2'b00}}) begin
      n_bad++;
      $display("FAIL reset_counters: got %0h/%0h expected 0/0",
               hz.StallCycles, hz.FlushCycles);
    end
    // Forwarding conditions present during reset must still select RF.
    hz.RegWriteM = 1'b1;
    hz.RdM       = 5'd3;
    hz.Rs1E      = 5'd3;
    hz.Rs2E      = 5'd3;
    #1;
    n_cmp++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_forward: got %b expected 0000",
               {hz.ForwardAE, hz.ForwardBE});
    end
    rst = 1'b0;
    idle();
    #1;
    n_cmp++;
    if ({hz.FlushD, hz.FlushE, hz.FlushW} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset_flushes: got %b expected 000",
               {hz.FlushD, hz.FlushE, hz.FlushW});
    end
    step();
    exp_stall = '0;
    exp_flush = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_forwarding();
    idle();
    hz.RegWriteM = 1'b1;
    hz.RdM       = 5'd5;
    hz.Rs1E      = 5'd5;
    hz.RegWriteW = 1'b1;
    hz.RdW       = 5'd5;
    #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b10) begin
      n_bad++;
      $display("FAIL fwd_a_mem_priority: got %b expected 10", hz.ForwardAE);
    end
    hz.RdM = 5'd0;
    #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b01) begin
      n_bad++;
      $display("FAIL fwd_a_wb_rdm0: got %b expected 01", hz.ForwardAE);
    end
    hz.Rs2E = 5'd5;
    #1;
    n_cmp++;
    if (hz.ForwardBE !== 2'b01) begin
      n_bad++;
      $display("FAIL fwd_b_wb: got %b expected 01", hz.ForwardBE);
    end
    hz.RegWriteM = 1'b0;
    hz.RegWriteW = 1'b0;
    #1;
    n_cmp++;
    if (hz.ForwardBE !== 2'b00) begin
      n_bad++;
      $display("FAIL fwd_b_no_write: got %b expected 00", hz.ForwardBE);
    end
    // RdW == x0 must not forward even when Rs2E is also x0.
    hz.RegWriteW = 1'b1;
    hz.RdW       = 5'd0;
    hz.Rs2E      = 5'd0;
    #1;
    n_cmp++;
    if (hz.ForwardBE !== 2'b00) begin
      n_bad++;
      $display("FAIL fwd_b_x0: got %b expected 00", hz.ForwardBE);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {exp_stall, exp_flush}) begin
      n_bad++;
      $display("FAIL fwd_counters: got %0h/%0h expected %0h/%0h",
               hz.StallCycles, hz.FlushCycles, exp_stall, exp_flush);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_load_use();
    idle();
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd7;
    hz.Rs2D       = 5'd7;
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.StallM, hz.FlushD, hz.FlushW}
        !== 7'b1110000) begin
      n_bad++;
      $display("FAIL load_use_ctrl: got %b expected 1110000",
               {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.StallM, hz.FlushD, hz.FlushW});
    end
    step();
    exp_stall = exp_stall + 1'b1;
    idle();
    #1;
    n_cmp++;
    if (hz.StallCycles !== exp_stall) begin
      n_bad++;
      $display("FAIL load_use_count: got %0h expected %0h", hz.StallCycles, exp_stall);
    end
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
      n_bad++;
      $display("FAIL load_use_one_cycle: got %b expected 000",
               {hz.StallF, hz.StallD, hz.FlushE});
    end
    // A load into x0 is never a dependency.
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd0;
    hz.Rs1D       = 5'd0;
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
      n_bad++;
      $display("FAIL load_use_x0: got %b expected 000",
               {hz.StallF, hz.StallD, hz.FlushE});
    end
    idle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_branch_vs_load_use();
    idle();
    hz.ResultSrcE = 2'b01;
    hz.RdE        = 5'd9;
    hz.Rs1D       = 5'd9;
    hz.PCSrcE     = 1'b1;
    #1;
    n_cmp++;
    if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD} !== 4'b1100) begin
      n_bad++;
      $display("FAIL branch_wins: got %b expected 1100",
               {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD});
    end
    step();
    exp_flush = exp_flush + 1'b1;
    idle();
    #1;
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {exp_stall, exp_flush}) begin
      n_bad++;
      $display("FAIL branch_counters: got %0h/%0h expected %0h/%0h",
               hz.StallCycles, hz.FlushCycles, exp_stall, exp_flush);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_cache_miss();
    idle();
    // Miss and ready together in RUN is a hit.
    hz.CacheMissM  = 1'b1;
    hz.CacheReadyM = 1'b1;
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallM, hz.FlushW} !== 3'b000) begin
      n_bad++;
      $display("FAIL miss_ready_hit: got %b expected 000",
               {hz.StallF, hz.StallM, hz.FlushW});
    end
    step();
    hz.CacheReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushD, hz.FlushE}
          !== 7'b1111100) begin
        n_bad++;
        $display("FAIL miss_stall_cycle%0d: got %b expected 1111100", i,
                 {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushD, hz.FlushE});
      end
      step();
    end
    exp_stall = exp_stall + 8'd4;
    hz.CacheMissM  = 1'b0;
    hz.CacheReadyM = 1'b1;
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} !== 5'b00000) begin
      n_bad++;
      $display("FAIL miss_release: got %b expected 00000",
               {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW});
    end
    n_cmp++;
    if (hz.StallCycles !== exp_stall) begin
      n_bad++;
      $display("FAIL miss_count: got %0h expected %0h", hz.StallCycles, exp_stall);
    end
    step();
    idle();
    #1;
    // Back in RUN: no miss, no ready -> no stall (MISS would still stall).
    n_cmp++;
    if ({hz.StallF, hz.StallM, hz.FlushW} !== 3'b000) begin
      n_bad++;
      $display("FAIL miss_back_to_run: got %b expected 000",
               {hz.StallF, hz.StallM, hz.FlushW});
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_miss_pending_branch();
    idle();
    hz.PCSrcE     = 1'b1;
    hz.CacheMissM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallM} !== 4'b0011) begin
        n_bad++;
        $display("FAIL miss_branch_held%0d: got %b expected 0011", i,
                 {hz.FlushD, hz.FlushE, hz.StallF, hz.StallM});
      end
      step();
    end
    exp_stall = exp_stall + 8'd3;
    hz.CacheMissM  = 1'b0;
    hz.CacheReadyM = 1'b1;
    #1;
    n_cmp++;
    if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallM} !== 4'b1100) begin
      n_bad++;
      $display("FAIL miss_branch_release: got %b expected 1100",
               {hz.FlushD, hz.FlushE, hz.StallF, hz.StallM});
    end
    step();
    exp_flush = exp_flush + 1'b1;
    idle();
    #1;
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {exp_stall, exp_flush}) begin
      n_bad++;
      $display("FAIL miss_branch_counters: got %0h/%0h expected %0h/%0h",
               hz.StallCycles, hz.FlushCycles, exp_stall, exp_flush);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_miss();
    idle();
    hz.CacheMissM = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW}
        !== 7'b0000111) begin
      n_bad++;
      $display("FAIL rst_mid_miss_ctrl: got %b expected 0000111",
               {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW});
    end
    step();
    #1;
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {TB_DW{2'b00}}) begin
      n_bad++;
      $display("FAIL rst_mid_miss_counters: got %0h/%0h expected 0/0",
               hz.StallCycles, hz.FlushCycles);
    end
    rst = 1'b0;
    idle();
    #1;
    n_cmp++;
    if ({hz.StallF, hz.StallM, hz.FlushW} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_mid_miss_run: got %b expected 000",
               {hz.StallF, hz.StallM, hz.FlushW});
    end
    step();
    exp_stall = '0;
    exp_flush = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_saturation();
    idle();
    all_ones = '1;
    hz.CacheMissM = 1'b1;
    for (int i = 0; i < 300; i++) step();
    n_cmp++;
    if (hz.StallCycles !== all_ones) begin
      n_bad++;
      $display("FAIL sat_reach: got %0h expected %0h", hz.StallCycles, all_ones);
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if ({hz.StallCycles, hz.StallF} !== {all_ones, 1'b1}) begin
      n_bad++;
      $display("FAIL sat_hold: got %0h stall=%b expected %0h stall=1",
               hz.StallCycles, hz.StallF, all_ones);
    end
    hz.CacheMissM  = 1'b0;
    hz.CacheReadyM = 1'b1;
    step();
    idle();
    #1;
    n_cmp++;
    if ({hz.StallCycles, hz.FlushCycles} !== {all_ones, exp_flush}) begin
      n_bad++;
      $display("FAIL sat_after_release: got %0h/%0h expected %0h/%0h",
               hz.StallCycles, hz.FlushCycles, all_ones, exp_flush);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_stall = '0;
    exp_flush = '0;
    all_ones  = '1;
    rst       = 1'b1;
    idle();

    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load_use();
    test_cache_miss();
    test_miss_pending_branch();
    test_reset_mid_miss();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall/flush sequencer for the 5-stage RV32I core. Sits beside the decode stage and drives the stall/clear controls of the fetch, decode, execute and memory pipeline registers. Resolves register-operand forwarding, load-use stalls, taken-branch/jump flushes and multi-cycle data-cache misses through a small FSM. Also keeps saturating performance counters for stall and flush cycles.

## Interface
- `DATA_WIDTH`, 32: performance counter width.
- `ADDR_WIDTH`, 5: register address width.

Clock and reset are fixed: single clock `clk`; `rst` is synchronous and active-high.

- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `Rs1D`, `Rs2D`  in  ADDR_WIDTH  decode-stage source registers
- `Rs1E`, `Rs2E`, `RdE`  in  ADDR_WIDTH  execute-stage sources and destination
- `ResultSrcE`  in  2  2'b01 marks a load in E
- `PCSrcE`  in  1  taken branch or jump resolved in E
- `RegWriteM`, `RdM`  in  1 / ADDR_WIDTH  memory-stage write-back info
- `RegWriteW`, `RdW`  in  1 / ADDR_WIDTH  writeback-stage info
- `CacheMissM`  in  1  data-cache miss for the access in M
- `CacheReadyM`  in  1  miss data valid this cycle
- `StallF`, `StallD`, `StallE`, `StallM`  out  1  hold the respective pipeline register
- `FlushD`, `FlushE`, `FlushW`  out  1  clear the respective pipeline register
- `ForwardAE`, `ForwardBE`  out  2  ALU operand select: 00 = register file, 01 = resultW, 10 = ALUResultM
- `StallCycles`  out  DATA_WIDTH  cycles with any stall asserted
- `FlushCycles`  out  DATA_WIDTH  cycles with FlushD asserted

## Operation
- FSM states are `RUN` and `MISS`. Reset enters `RUN`.
- `RUN` to `MISS`: `CacheMissM`=1 and `CacheReadyM`=0.
- `MISS` to `RUN`: `CacheReadyM`=1.
- `CacheMissM` and `CacheReadyM` both high in `RUN`: treat as a hit with no stall.
- **Miss stall** (`RUN` with `CacheMissM` and not ready, or `MISS` and not ready):
  - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
  - `FlushD` and `FlushE` = 0. A pending `PCSrcE` is held and acted on after release.
- **Load-use** (`ResultSrcE`==01, `RdE`!=0, `RdE` equals `Rs1D` or `Rs2D`), only when no miss stall: `StallF` = `StallD` = 1 and `FlushE` = 1.
- **Branch** (`PCSrcE`), only when no miss stall: `FlushD` = 1 and `FlushE` = 1. `StallF`/`StallD` from a simultaneous load-use are suppressed, because the branch wins.
- Priority: `rst` > miss stall > branch > load-use.
- **Forwarding**, for operand A (B is identical using `Rs2E`):
  - 10 if `RegWriteM`, `RdM`!=0 and `RdM`==`Rs1E`.
  - Otherwise 01 if `RegWriteW`, `RdW`!=0 and `RdW`==`Rs1E`.
  - Otherwise 00.
  - Forwarding is computed in every state.
- **Counters**:
  - `StallCycles` += 1 in every cycle where any `Stall*` output is 1.
  - `FlushCycles` += 1 in every cycle where `FlushD` is 1.
  - Both saturate at all-ones and never wrap.
- **Reset values** (while `rst`=1):
  - All `Stall*` = 0.
  - `FlushD` = `FlushE` = `FlushW` = 1.
  - Forward selects = 00.
  - Counters = 0, state = `RUN`.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered state, taking effect in the same cycle.
- The state and both counters update on the `clk` rising edge.
- A miss stalls starting in the cycle `CacheMissM` rises. The stall continues through every `MISS` cycle.
- Release happens in the cycle `CacheReadyM`=1: all stalls go to 0, so M and W advance on that edge. The cache deasserts `CacheMissM` in the same cycle.
- A load-use stall lasts exactly 1 cycle. The bubble is in E, and the load then forwards via W.
- A flush lasts 1 cycle per `PCSrcE` assertion.
- `rst` asserted during `MISS`: state returns to `RUN` on the next edge, with reset outputs driven during the `rst` cycle.

## Structure
- Shared package `hazard_pkg`:
  - FSM state enum `hz_state_t`.
  - Forward select constants `FWD_RF` = 00, `FWD_W` = 01, `FWD_M` = 10.
  - `RESULT_SRC_LOAD` = 2'b01.
- One sub-module, `forward_sel`: combinational single-operand forwarding selector, instantiated twice (A and B).
- The FSM and counters live in `hazard_controller`.

## Test plan
- **Forwarding:** `RegWriteM`=1, `RdM`=5, `Rs1E`=5, and also `RegWriteW`=1, `RdW`=5 -> `ForwardAE`=10. Then `RdM`=0 -> `ForwardAE`=01. Then `Rs2E`=5 with `RegWriteM`=0 and `RegWriteW`=0 -> `ForwardBE`=00.
- **Load-use:** `ResultSrcE`=01, `RdE`=7, `Rs2D`=7 -> `StallF`=`StallD`=`FlushE`=1 for 1 cycle. `StallCycles` goes 0 -> 1.
- **Branch vs load-use:** `PCSrcE`=1 together with a load-use hit -> `FlushD`=`FlushE`=1 and `StallF`=`StallD`=0. `FlushCycles` increments.
- **Cache miss:** `CacheMissM`=1 for 4 cycles, then `CacheReadyM`=1 -> `StallF`..`StallM` and `FlushW` = 1 for 4 cycles, then all 0 in the ready cycle. `StallCycles` = 4 and the state is back in `RUN`.
- **Miss with pending branch:** `PCSrcE`=1 throughout the miss -> `FlushD`=0 during the miss, then `FlushD`=1 in the ready cycle.
- **Reset mid-miss, and saturation:** assert `rst` during `MISS` -> all flushes = 1, stalls = 0, counters = 0, and `RUN` on the next cycle. Force `StallCycles` to all-ones with continuous stalls -> it stays all-ones.
